nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 128 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder run one 4-bit carry-skip nibble per cycle, LSB nibble first.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_co;

  // Ripple chain, with the carry bypassing it whenever all four bits propagate.
  function automatic logic [4:0] nibble_add(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci);
    logic [3:0] p, s;
    logic       c;
    p = x ^ y;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = p[i] ^ c;
      c    = (x[i] & y[i]) | (p[i] & c);
    end
    return {((&p) ? ci : c), s};
  endfunction

  always_comb begin
    nib_a = a_q[{cnt_q, 2'b00} +: 4];
    nib_b = b_q[{cnt_q, 2'b00} +: 4];
    {nib_co, nib_s} = nibble_add(nib_a, nib_b, carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_co;
        if (cnt_q == LAST) begin
          cout_d  = nib_co;
          ovf_d   = (nib_a[3] == nib_b[3]) && (nib_s[3] != nib_a[3]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench over WIDTH=4, 16 and 32 instances.
module tb_nibble_serial_adder;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid[NI], in_ready[NI], out_valid[NI], out_ready[NI];
  logic        cin[NI], cout[NI], ovf[NI];
  logic [31:0] a[NI], b[NI], sum[NI];
  logic [33:0] exp_q[NI][$];
  int          acc_q[NI][$];
  bit          rand_done[NI];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 16 : 32);
  endfunction

  function automatic logic [31:0] mof(input int g);
    return (wof(g) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wof(g)) - 32'd1);
  endfunction

  // Reference: plain integer addition, then the signed-overflow rule on the operand MSBs.
  function automatic logic [33:0] model(input int g, input logic [31:0] av, input logic [31:0] bv,
                                        input logic c);
    logic [32:0] full;
    logic [31:0] m, s, am, bm;
    int          w;
    w    = wof(g);
    m    = mof(g);
    am   = av & m;
    bm   = bv & m;
    full = {1'b0, am} + {1'b0, bm} + {32'd0, c};
    s    = full[31:0] & m;
    return {(am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]), full[w], s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int g, input logic [31:0] av, input logic [31:0] bv, input logic c);
    exp_q[g].push_back(model(g, av, bv, c));
    acc_q[g].push_back(cyc + 1);
  endtask

  // Holds in_valid and scrambles operands while the block is busy; real operands go out when ready.
  task automatic send(input int g, input logic [31:0] av, input logic [31:0] bv, input logic c);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid[g] = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (in_ready[g]) begin
        a[g] = av; b[g] = bv; cin[g] = c;
        push(g, av, bv, c);
        ok = 1'b1;
      end else begin
        a[g] = $urandom; b[g] = $urandom; cin[g] = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid[g] = 1'b0;
    a[g] = $urandom; b[g] = $urandom;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input int g);
    for (int t = 0; t < 300 && exp_q[g].size() != 0; t++) begin
      @(negedge clk); #2;
    end
    @(negedge clk); #2;
    chk("drain", 64'(exp_q[g].size()), 64'd0);
  endtask

  task automatic rand_run(input int g);
    repeat (1000) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(g, $urandom, $urandom, 1'($urandom));
    end
    rand_done[g] = 1'b1;
  endtask

  task automatic rdy_rand(input int g);
    while (!rand_done[g]) begin
      @(negedge clk);
      out_ready[g] = 1'($urandom);
    end
    out_ready[g] = 1'b1;
  endtask

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = (g == 0) ? 4 : ((g == 1) ? 16 : 32);
      logic [W-1:0] s_w;

      nibble_serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .a        (a[g][W-1:0]),
        .b        (b[g][W-1:0]),
        .cin      (cin[g]),
        .out_valid(out_valid[g]),
        .out_ready(out_ready[g]),
        .sum      (s_w),
        .cout     (cout[g]),
        .overflow (ovf[g])
      );
      assign sum[g] = 32'(s_w);

      initial begin : monitor
        logic        pv;
        logic [33:0] prev, cur, e;
        pv = 1'b0;
        prev = '0;
        forever begin
          @(negedge clk); #1;
          cur = {ovf[g], cout[g], sum[g]};
          if (!rst_n || !out_valid[g]) begin
            pv = 1'b0;
          end else begin
            chk($sformatf("w%0d_in_ready_in_done", W), 64'(in_ready[g]), 64'd0);
            if (pv) chk($sformatf("w%0d_hold", W), 64'(cur), 64'(prev));
            else if (acc_q[g].size() == 0) chk($sformatf("w%0d_unexpected_out_valid", W), 64'd1, 64'd0);
            else chk($sformatf("w%0d_latency", W), 64'(cyc - acc_q[g][0]), 64'(W / 4));
            if (out_ready[g]) begin
              if (exp_q[g].size() == 0) begin
                chk($sformatf("w%0d_result_unexpected", W), 64'(cur), 64'd0);
              end else begin
                e = exp_q[g].pop_front();
                void'(acc_q[g].pop_front());
                chk($sformatf("w%0d_result", W), 64'(cur), 64'(e));
              end
              pv = 1'b0;
            end else begin
              pv   = 1'b1;
              prev = cur;
            end
          end
        end
      end
    end
  endgenerate

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0, t1;
    bit  seen;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0; out_ready[g] = 1'b1; a[g] = '0; b[g] = '0; cin[g] = 1'b0;
      rand_done[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset_in_ready", 64'(in_ready[g]), 64'd1);
      chk("reset_out_valid", 64'(out_valid[g]), 64'd0);
      chk("reset_sum", 64'(sum[g]), 64'd0);
      chk("reset_cout_ovf", 64'({cout[g], ovf[g]}), 64'd0);
    end
    rst_n = 1'b1;

    send(1, 32'hFFFF, 32'h0000, 1'b1);
    send(1, 32'h7FFF, 32'h0001, 1'b0);
    send(1, 32'h8000, 32'h8000, 1'b0);
    send(1, 32'h0F0F, 32'h00F1, 1'b0);
    wait_drain(1);
    chk("skip_sum", 64'(sum[1]), 64'h1000);
    chk("skip_cout_ovf", 64'({cout[1], ovf[1]}), 64'd0);

    // Backpressure, then a release pulse with the next operands already waiting.
    out_ready[1] = 1'b0;
    send(1, 32'h1234, 32'hEDCC, 1'b0);
    for (int t = 0; t < 20 && !out_valid[1]; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("busy_before_pulse", 64'(in_ready[1]), 64'd0);
    a[1] = 32'hA5A5; b[1] = 32'h5A5B; cin[1] = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    @(negedge clk);
    chk("ready_after_pulse", 64'(in_ready[1]), 64'd1);
    push(1, 32'hA5A5, 32'h5A5B, 1'b0);
    t0 = cyc + 1;
    t1 = t0;
    @(negedge clk);
    a[1] = 32'h8001; b[1] = 32'hFFFF; cin[1] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (in_ready[1]) begin
        push(1, 32'h8001, 32'hFFFF, 1'b1);
        t1 = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("b2b_period", 64'(t1 - t0), 64'd6);
    wait_drain(1);

    // Asynchronous reset in the middle of RUN drops the operation.
    send(1, 32'hBEEF, 32'h1357, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_in_ready", 64'(in_ready[1]), 64'd1);
    chk("midrun_reset_out_valid", 64'(out_valid[1]), 64'd0);
    chk("midrun_reset_sum", 64'(sum[1]), 64'd0);
    chk("midrun_reset_cout_ovf", 64'({cout[1], ovf[1]}), 64'd0);
    exp_q[1].delete();
    acc_q[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[1]) seen = 1'b1;
    end
    chk("no_stale_result", 64'(seen), 64'd0);

    fork
      rand_run(0);
      rand_run(2);
      rdy_rand(0);
      rdy_rand(2);
    join
    wait_drain(0);
    wait_drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
